// File: rtl/led_frame_dma.sv
// ---------------------------------------------------------------------------
// led_frame_dma
//
// Copies one LED frame (packed 24-bit RGB pixels held in 32-bit words) from
// system memory into the LED matrix frame memory. The CPU programs the engine
// through a small Wishbone register slave. Source reads and destination writes
// go out on two independent classic-cycle Wishbone masters. In auto mode a
// new frame is copied on every frame_tick_i from the display side.
//
// Register map (cfg_adr_i):
//   0 CTRL    bit0 start (W1 pulse), bit1 auto, bit2 abort (W1 pulse), bit3 ie
//   1 STATUS  bit0 busy, bit1 done (W1C), bit2 err (W1C), bit3 overrun (W1C)
//   2 SRC     source byte address
//   3 DST     destination word address
//   4 COUNT   words to copy
//   5 FRAMES  completed transfers (read-only, wraps)
//   6,7       read 0, writes ignored
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cfg_*                 register slave (cyc/stb/we/adr/dat in, dat/ack out)
//   src_*                 read-only master toward system memory
//   dst_*                 write-only master toward matrix memory
//   frame_tick_i          one-cycle display frame pulse, synchronous to clk_i
//   irq_o                 level interrupt, done & ie
//
// States:
//   IDLE | waiting for start or an auto-mode frame tick
//   RD   | source read in flight
//   WR   | destination write in flight
//   DONE | one cycle: set done, count the frame
// ---------------------------------------------------------------------------
module led_frame_dma #(
    parameter int WORDS_MAX = 512,
    parameter int SRC_AW    = 32,
    parameter int DST_AW    = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              cfg_cyc_i,
    input  logic              cfg_stb_i,
    input  logic              cfg_we_i,
    input  logic [2:0]        cfg_adr_i,
    input  logic [31:0]       cfg_dat_i,
    output logic [31:0]       cfg_dat_o,
    output logic              cfg_ack_o,

    output logic              src_cyc_o,
    output logic              src_stb_o,
    output logic              src_we_o,
    output logic [3:0]        src_sel_o,
    output logic [SRC_AW-1:0] src_adr_o,
    input  logic [31:0]       src_dat_i,
    input  logic              src_ack_i,
    input  logic              src_err_i,

    output logic              dst_cyc_o,
    output logic              dst_stb_o,
    output logic              dst_we_o,
    output logic [3:0]        dst_sel_o,
    output logic [DST_AW-1:0] dst_adr_o,
    output logic [31:0]       dst_dat_o,
    input  logic              dst_ack_i,
    input  logic              dst_err_i,

    input  logic              frame_tick_i,
    output logic              irq_o
);

    localparam int CW = $clog2(WORDS_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // configuration registers
    logic              ack_q;
    logic [31:0]       rdata_q;
    logic              auto_q;
    logic              ie_q;
    logic              start_q;
    logic              abort_q;
    logic              done_q;
    logic              err_q;
    logic              overrun_q;
    logic [SRC_AW-1:0] src_q;
    logic [DST_AW-1:0] dst_q;
    logic [CW-1:0]     count_q;
    logic [15:0]       frames_q;

    // working copies used during a transfer
    logic [SRC_AW-1:0] wsrc_q;
    logic [DST_AW-1:0] wdst_q;
    logic [CW-1:0]     wrem_q;
    logic [31:0]       hold_q;
    logic              abort_pend_q;
    logic              abort_pend_d;

    logic busy;
    logic req;
    logic wr_en;
    logic wr_ctrl;
    logic wr_status;
    logic abort_now;

    // FSM strobes
    logic latch;
    logic capture;
    logic step;
    logic set_err;
    logic finish;

    assign busy      = (state_q != IDLE);
    assign req       = cfg_cyc_i & cfg_stb_i & ~ack_q;
    assign wr_en     = req & cfg_we_i;
    assign wr_ctrl   = wr_en & (cfg_adr_i == 3'd0);
    assign wr_status = wr_en & (cfg_adr_i == 3'd1);

    // An abort pulse landing in the same cycle as ack/err still counts.
    assign abort_now = abort_pend_q | abort_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        capture = 1'b0;
        step    = 1'b0;
        set_err = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                // start and tick together still launch only one transfer
                if (start_q | (auto_q & frame_tick_i)) begin
                    latch   = 1'b1;
                    state_d = (count_q == '0) ? DONE : RD;
                end
            end
            RD: begin
                if (src_err_i) begin
                    set_err = 1'b1;
                    state_d = IDLE;
                end else if (src_ack_i) begin
                    capture = 1'b1;
                    state_d = abort_now ? IDLE : WR;
                end
            end
            WR: begin
                if (dst_err_i) begin
                    set_err = 1'b1;
                    state_d = IDLE;
                end else if (dst_ack_i) begin
                    step = 1'b1;
                    if (abort_now) begin
                        state_d = IDLE;
                    end else if (wrem_q == CW'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            DONE: begin
                finish  = ~abort_now;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Abort is remembered only while a transfer is running and is
    // forgotten as soon as the engine is back in IDLE.
    always_comb begin
        abort_pend_d = abort_pend_q | (abort_q & busy);
        if (state_d == IDLE) begin
            abort_pend_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register slave
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            auto_q    <= 1'b0;
            ie_q      <= 1'b0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            count_q   <= '0;
            frames_q  <= '0;
        end else begin
            ack_q   <= req;
            start_q <= wr_ctrl & cfg_dat_i[0];
            abort_q <= wr_ctrl & cfg_dat_i[2];

            if (req) begin
                case (cfg_adr_i)
                    3'd0:    rdata_q <= {28'h0, ie_q, 1'b0, auto_q, 1'b0};
                    3'd1:    rdata_q <= {28'h0, overrun_q, err_q, done_q, busy};
                    3'd2:    rdata_q <= 32'(src_q);
                    3'd3:    rdata_q <= 32'(dst_q);
                    3'd4:    rdata_q <= 32'(count_q);
                    3'd5:    rdata_q <= {16'h0, frames_q};
                    default: rdata_q <= '0;
                endcase
            end

            if (wr_ctrl) begin
                auto_q <= cfg_dat_i[1];
                ie_q   <= cfg_dat_i[3];
            end

            // transfer parameters are frozen while the engine is busy
            if (wr_en && !busy) begin
                case (cfg_adr_i)
                    3'd2:    src_q   <= cfg_dat_i[SRC_AW-1:0];
                    3'd3:    dst_q   <= cfg_dat_i[DST_AW-1:0];
                    3'd4:    count_q <= cfg_dat_i[CW-1:0];
                    default: ;
                endcase
            end

            // sticky flags: a new event wins over a simultaneous clear
            done_q    <= (done_q    & ~(wr_status & cfg_dat_i[1])) | finish;
            err_q     <= (err_q     & ~(wr_status & cfg_dat_i[2])) | set_err;
            overrun_q <= (overrun_q & ~(wr_status & cfg_dat_i[3]))
                         | (frame_tick_i & auto_q & busy);

            if (finish) begin
                frames_q <= frames_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transfer datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wsrc_q       <= '0;
            wdst_q       <= '0;
            wrem_q       <= '0;
            hold_q       <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            abort_pend_q <= abort_pend_d;
            if (latch) begin
                wsrc_q <= src_q;
                wdst_q <= dst_q;
                wrem_q <= count_q;
            end else if (step) begin
                // both addresses wrap naturally at their register width
                wsrc_q <= wsrc_q + SRC_AW'(4);
                wdst_q <= wdst_q + DST_AW'(1);
                wrem_q <= wrem_q - CW'(1);
            end
            if (capture) begin
                hold_q <= src_dat_i;
            end
        end
    end

    // Only the RGB bytes are forwarded; the top byte of each source word
    // is dropped.
    logic unused_hold;
    assign unused_hold = ^hold_q[31:24];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cfg_ack_o = ack_q;
    assign cfg_dat_o = rdata_q;

    assign src_cyc_o = (state_q == RD);
    assign src_stb_o = (state_q == RD);
    assign src_we_o  = 1'b0;
    assign src_sel_o = 4'hF;
    assign src_adr_o = wsrc_q;

    assign dst_cyc_o = (state_q == WR);
    assign dst_stb_o = (state_q == WR);
    assign dst_we_o  = (state_q == WR);
    assign dst_sel_o = 4'h7;
    assign dst_adr_o = wdst_q;
    assign dst_dat_o = {8'h00, hold_q[23:0]};

    assign irq_o = done_q & ie_q;

endmodule

// File: tb/tb_led_frame_dma.sv
module tb_led_frame_dma;

    localparam int DST_AW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cfg_cyc, cfg_stb, cfg_we;
    logic [2:0]  cfg_adr;
    logic [31:0] cfg_dat;
    logic [31:0] cfg_dat_o;
    logic        cfg_ack;
    logic        src_cyc_o, src_stb_o, src_we_o;
    logic [3:0]  src_sel_o;
    logic [31:0] src_adr_o;
    logic [31:0] src_dat;
    logic        src_ack, src_err;
    logic        dst_cyc_o, dst_stb_o, dst_we_o;
    logic [3:0]  dst_sel_o;
    logic [8:0]  dst_adr_o;
    logic [31:0] dst_dat_o;
    logic        dst_ack, dst_err;
    logic        tick;
    logic        irq;

    led_frame_dma #(.WORDS_MAX(512), .SRC_AW(32), .DST_AW(DST_AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_cyc_i(cfg_cyc), .cfg_stb_i(cfg_stb), .cfg_we_i(cfg_we),
        .cfg_adr_i(cfg_adr), .cfg_dat_i(cfg_dat), .cfg_dat_o(cfg_dat_o), .cfg_ack_o(cfg_ack),
        .src_cyc_o(src_cyc_o), .src_stb_o(src_stb_o), .src_we_o(src_we_o),
        .src_sel_o(src_sel_o), .src_adr_o(src_adr_o), .src_dat_i(src_dat),
        .src_ack_i(src_ack), .src_err_i(src_err),
        .dst_cyc_o(dst_cyc_o), .dst_stb_o(dst_stb_o), .dst_we_o(dst_we_o),
        .dst_sel_o(dst_sel_o), .dst_adr_o(dst_adr_o), .dst_dat_o(dst_dat_o),
        .dst_ack_i(dst_ack), .dst_err_i(dst_err),
        .frame_tick_i(tick), .irq_o(irq)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [8:0]  adr;
        logic [31:0] dat;
    } dst_t;

    logic [31:0] exp_src_q[$];
    dst_t        exp_dst_q[$];
    int          exp_frames = 0;
    logic [31:0] mem_seed = 32'h1234_5678;

    int src_lat = 1, dst_lat = 1;
    int src_err_idx = -1, dst_err_idx = -1;
    int src_n = 0, dst_n = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // system memory contents as seen by the bench
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'hAABB_CCDD;
        return (a * 32'h9E37_79B1) ^ mem_seed;
    endfunction

    // expected bus traffic of one transfer, straight from the copy rules
    function automatic void expect_xfer(input logic [31:0] s, input logic [8:0] d,
                                        input int cnt, input int err_at, input int abort_at);
        logic [31:0] a;
        logic [31:0] w;
        dst_t        t;
        for (int i = 0; i < cnt; i++) begin
            a = s + 32'(4 * i);
            exp_src_q.push_back(a);
            if (i == err_at) break;
            w = mem_fn(a);
            t.adr = d + 9'(i);
            t.dat = {8'h00, w[23:0]};
            exp_dst_q.push_back(t);
            if (i == abort_at) break;
        end
    endfunction

    // ---------------- slaves ----------------
    initial begin
        int w;
        w = 0;
        src_ack = 0; src_err = 0; src_dat = 0;
        forever begin
            @(posedge clk); #1;
            src_ack = 0; src_err = 0;
            if (rst) w = 0;
            else if (src_cyc_o && src_stb_o) begin
                if (w >= src_lat) begin
                    w = 0;
                    if (src_n == src_err_idx) src_err = 1;
                    else begin
                        src_ack = 1;
                        src_dat = mem_fn(src_adr_o);
                    end
                    src_n++;
                end else w++;
            end else w = 0;
        end
    end

    initial begin
        int w;
        w = 0;
        dst_ack = 0; dst_err = 0;
        forever begin
            @(posedge clk); #1;
            dst_ack = 0; dst_err = 0;
            if (rst) w = 0;
            else if (dst_cyc_o && dst_stb_o) begin
                if (w >= dst_lat) begin
                    w = 0;
                    if (dst_n == dst_err_idx) dst_err = 1;
                    else dst_ack = 1;
                    dst_n++;
                end else w++;
            end else w = 0;
        end
    end

    // ---------------- monitors ----------------
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (src_cyc_o && src_stb_o && (src_ack || src_err)) begin
                if (exp_src_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL src_unexpected: read at 0x%08h, none expected", src_adr_o);
                end else begin
                    e = exp_src_q.pop_front();
                    check("src_adr", src_adr_o, e);
                    check("src_sel", 32'(src_sel_o), 32'hF);
                    check("src_we", 32'(src_we_o), 32'h0);
                end
            end
        end
    end

    initial begin
        dst_t e;
        forever begin
            @(negedge clk);
            if (dst_cyc_o && dst_stb_o && (dst_ack || dst_err)) begin
                if (exp_dst_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL dst_unexpected: write at 0x%03h, none expected", dst_adr_o);
                end else begin
                    e = exp_dst_q.pop_front();
                    check("dst_adr", 32'(dst_adr_o), 32'(e.adr));
                    check("dst_dat", dst_dat_o, e.dat);
                    check("dst_sel", 32'(dst_sel_o), 32'h7);
                    check("dst_we", 32'(dst_we_o), 32'h1);
                end
            end
        end
    end

    // ---------------- cfg port helpers ----------------
    task automatic cfg_xfer(input logic we, input logic [2:0] a, input logic [31:0] d,
                            output logic [31:0] q);
        int n;
        n = 0;
        @(negedge clk);
        cfg_cyc = 1; cfg_stb = 1; cfg_we = we; cfg_adr = a; cfg_dat = d;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!cfg_ack && n < 8);
        if (!cfg_ack) begin
            vectors++; miscompares++;
            $display("FAIL cfg_ack_timeout: adr %0d got no ack, expected ack", a);
        end
        q = cfg_dat_o;
        cfg_cyc = 0; cfg_stb = 0; cfg_we = 0;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] q;
        cfg_xfer(1'b1, a, d, q);
    endtask

    task automatic cfg_read(input logic [2:0] a, output logic [31:0] q);
        cfg_xfer(1'b0, a, 32'h0, q);
    endtask

    task automatic program_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] c);
        cfg_write(3'd2, s);
        cfg_write(3'd3, d);
        cfg_write(3'd4, c);
        src_n = 0; dst_n = 0;
    endtask

    task automatic pulse_tick();
        @(negedge clk); tick = 1;
        @(negedge clk); tick = 0;
    endtask

    task automatic wait_idle(output logic [31:0] st);
        st = 32'h1;
        for (int n = 0; n < 3000 && st[0]; n++) cfg_read(3'd1, st);
        if (st[0]) begin
            vectors++; miscompares++;
            $display("FAIL idle_timeout: busy still 1, expected 0");
        end
    endtask

    task automatic check_drained(string tag);
        check({tag, "_src_left"}, 32'(exp_src_q.size()), 32'h0);
        check({tag, "_dst_left"}, 32'(exp_dst_q.size()), 32'h0);
    endtask

    task automatic check_frames();
        logic [31:0] q;
        cfg_read(3'd5, q);
        check("frames", q, 32'(exp_frames & 16'hFFFF));
    endtask

    task automatic check_all_zero(string tag);
        logic [31:0] q;
        for (int a = 0; a < 8; a++) begin
            cfg_read(3'(a), q);
            check($sformatf("%s_reg%0d", tag, a), q, 32'h0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] st, q, s, d, c;

        rst = 1; tick = 0;
        cfg_cyc = 0; cfg_stb = 0; cfg_we = 0; cfg_adr = 0; cfg_dat = 0;
        repeat (3) @(negedge clk);
        rst = 0;

        // reset state
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_src_cyc", 32'(src_cyc_o), 32'h0);
        check("rst_dst_cyc", 32'(dst_cyc_o), 32'h0);
        check_all_zero("rst");
        cfg_write(3'd6, 32'hFFFF_FFFF);
        cfg_read(3'd6, q);
        check("reg6_ignored", q, 32'h0);

        // basic 4-word copy
        program_xfer(32'h1000, 32'h0, 32'd4);
        expect_xfer(32'h1000, 9'h0, 4, -1, -1);
        cfg_write(3'd0, 32'h1);
        wait_idle(st);
        exp_frames++;
        check("t1_status", st, 32'h2);
        check_frames();
        check_drained("t1");
        cfg_write(3'd1, 32'hE);

        // zero-length transfer with interrupt
        program_xfer(32'h2000, 32'h0, 32'd0);
        cfg_write(3'd0, 32'h9);
        @(posedge clk); #1;
        check("t2_irq_early", 32'(irq), 32'h0);
        @(posedge clk); #1;
        check("t2_irq", 32'(irq), 32'h1);
        wait_idle(st);
        exp_frames++;
        check("t2_status", st, 32'h2);
        cfg_read(3'd0, q);
        check("t2_ctrl_read", q, 32'h8);
        cfg_write(3'd1, 32'h2);
        check("t2_irq_cleared", 32'(irq), 32'h0);
        check_frames();
        check_drained("t2");
        cfg_write(3'd0, 32'h0);

        // auto mode, ticks spaced wider than a frame copy
        mem_seed = $urandom;
        src_lat = 1; dst_lat = 1;
        program_xfer(32'h2000, 32'h0, 32'd512);
        cfg_write(3'd0, 32'h2);
        for (int k = 0; k < 3; k++) begin
            src_n = 0; dst_n = 0;
            expect_xfer(32'h2000, 9'h0, 512, -1, -1);
            pulse_tick();
            repeat (3000) @(posedge clk);
            exp_frames++;
        end
        cfg_read(3'd1, st);
        check("t3_status", st, 32'h2);
        check_frames();
        check_drained("t3a");
        // a frame copy takes more than 2000 cycles, so the later ticks land while busy
        src_n = 0; dst_n = 0;
        expect_xfer(32'h2000, 9'h0, 512, -1, -1);
        pulse_tick();
        repeat (800) @(posedge clk);
        pulse_tick();
        repeat (800) @(posedge clk);
        pulse_tick();
        cfg_write(3'd0, 32'h0);
        wait_idle(st);
        exp_frames++;
        check("t3_overrun", st, 32'hA);
        check_frames();
        check_drained("t3b");
        cfg_write(3'd1, 32'hE);

        // start write and frame tick in the same cycle
        program_xfer(32'h0000_8000, 32'h20, 32'd3);
        expect_xfer(32'h0000_8000, 9'h20, 3, -1, -1);
        cfg_write(3'd0, 32'h3);
        pulse_tick();
        cfg_write(3'd0, 32'h0);
        wait_idle(st);
        exp_frames++;
        check("tsim_status", st, 32'h2);
        check_frames();
        check_drained("tsim");
        cfg_write(3'd1, 32'hE);

        // abort during the write of word 10
        src_lat = 1; dst_lat = 5;
        program_xfer(32'h0000_4000, 32'h0, 32'd16);
        expect_xfer(32'h0000_4000, 9'h0, 16, -1, 10);
        cfg_write(3'd0, 32'h1);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(dst_cyc_o && dst_adr_o == 9'd10) && n < 2000);
            if (n >= 2000) begin
                vectors++; miscompares++;
                $display("FAIL abort_wait: word 10 write not seen, expected it");
            end
        end
        cfg_write(3'd0, 32'h4);
        wait_idle(st);
        check("t4_status", st, 32'h0);
        check_frames();
        repeat (20) @(posedge clk);
        check_drained("t4");
        dst_lat = 1;

        // source error on word 2
        program_xfer(32'h0000_5000, 32'h10, 32'd5);
        src_err_idx = 2;
        expect_xfer(32'h0000_5000, 9'h10, 5, 2, -1);
        cfg_write(3'd0, 32'h1);
        wait_idle(st);
        src_err_idx = -1;
        check("t5_status", st, 32'h4);
        check_frames();
        check_drained("t5");
        cfg_write(3'd1, 32'h4);
        cfg_read(3'd1, st);
        check("t5_err_cleared", st, 32'h0);

        // both addresses wrap
        program_xfer(32'hFFFF_FFF8, 32'h1FE, 32'd4);
        expect_xfer(32'hFFFF_FFF8, 9'h1FE, 4, -1, -1);
        cfg_write(3'd0, 32'h1);
        wait_idle(st);
        exp_frames++;
        check("t5w_status", st, 32'h2);
        check_frames();
        check_drained("t5w");
        cfg_write(3'd1, 32'hE);

        // randomized transfers
        for (int k = 0; k < 6; k++) begin
            mem_seed = $urandom;
            src_lat = $urandom_range(0, 3);
            dst_lat = $urandom_range(0, 3);
            s = $urandom & 32'hFFFF_FFFC;
            d = $urandom_range(0, 511);
            c = $urandom_range(1, 12);
            program_xfer(s, d, c);
            expect_xfer(s, 9'(d), int'(c), -1, -1);
            cfg_write(3'd0, 32'h1);
            wait_idle(st);
            exp_frames++;
            check("rnd_status", st, 32'h2);
            check_drained("rnd");
            cfg_write(3'd1, 32'h2);
        end
        check_frames();

        // SRC write while busy, then reset in the middle of a read
        src_lat = 20; dst_lat = 1;
        program_xfer(32'h0000_3000, 32'h5, 32'd2);
        expect_xfer(32'h0000_3000, 9'h5, 2, -1, -1);
        cfg_write(3'd0, 32'h1);
        begin
            int n;
            n = 0;
            while (!src_cyc_o && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        cfg_write(3'd2, 32'h5555_0000);
        cfg_read(3'd2, q);
        check("t6_src_frozen", q, 32'h0000_3000);
        cfg_read(3'd1, st);
        check("t6_busy", st, 32'h1);
        @(negedge clk);
        #2 rst = 1;
        #1;
        check("t6_rst_src_cyc", 32'(src_cyc_o), 32'h0);
        check("t6_rst_src_stb", 32'(src_stb_o), 32'h0);
        exp_src_q.delete();
        exp_dst_q.delete();
        exp_frames = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        check("t6_irq", 32'(irq), 32'h0);
        check_all_zero("t6");

        // engine works again after reset
        src_lat = 1;
        program_xfer(32'h0000_6000, 32'h40, 32'd2);
        expect_xfer(32'h0000_6000, 9'h40, 2, -1, -1);
        cfg_write(3'd0, 32'h1);
        wait_idle(st);
        exp_frames++;
        check("t6_after_status", st, 32'h2);
        check_frames();
        check_drained("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_frame_dma.md
Name: led_frame_dma

Overview:
Wishbone DMA engine that copies one LED frame (packed 24-bit RGB pixels in 32-bit words) from system memory into the LED matrix frame memory.
- Runs in the clk_i domain. The CPU configures it through a register slave port.
- It reads through a master port and writes through a second master port that connects to the matrix memory's bus-side port.
- Supports one-shot transfers and auto mode. In auto mode a new frame is copied on every frame_tick from the display side.

Parameters:
- WORDS_MAX, 512, maximum transfer length in words (COL*ROW for a 32x16 panel); sets the width of COUNT.
- SRC_AW, 32, source byte-address width.
- DST_AW, 9, destination word-address width (matrix memory address).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous, active-high reset.
- cfg  if_wb.slave  -  register port: word address adr[2:0], 32-bit data.
- src  if_wb.master  -  read-only master toward system memory.
- dst  if_wb.master  -  write-only master toward matrix memory.
- frame_tick  input  1  single-cycle pulse, already synchronous to clk_i.
- irq  output  1  level interrupt, = done & ie.

Behaviour:
- Registers (cfg.adr[2:0]):
  - 0 CTRL: bit0 start (write-1 pulse), bit1 auto, bit2 abort (write-1 pulse), bit3 ie. Reads return auto and ie; start/abort read 0.
  - 1 STATUS: bit0 busy, bit1 done (sticky, write-1-clear), bit2 err (sticky, W1C), bit3 overrun (sticky, W1C).
  - 2 SRC: source byte address.
  - 3 DST: destination word address [DST_AW-1:0].
  - 4 COUNT: words to copy, [$clog2(WORDS_MAX+1)-1:0].
  - 5 FRAMES: read-only 16-bit count of completed transfers; wraps 0xFFFF->0.
  - 6, 7: read 0; writes ignored.
- cfg handshake:
  - ack = registered (cyc & stb & ~ack); exactly one cycle of latency, one-cycle pulse.
  - Write takes effect on the ack cycle. Read data is registered with the ack.
  - Writes to SRC/DST/COUNT while busy are ignored; they still get acked.
- State machine, states IDLE, RD, WR, DONE:
  - IDLE: start, or (auto & frame_tick), latches SRC/DST/COUNT into working counters.
    - COUNT=0: go to DONE with no bus cycles.
    - Otherwise: go to RD.
  - RD: assert src.cyc/stb, we=0, sel=4'hF, adr=working src.
    - On src.ack: capture dat into a 32-bit holding register, go to WR.
    - On src.err: set err, go to IDLE.
  - WR: assert dst.cyc/stb/we, sel=4'h7, dat={8'h0, hold[23:0]}, adr=working dst.
    - On dst.ack: src += 4, dst += 1, remaining -= 1. If remaining becomes 0, go to DONE; else go to RD.
    - On dst.err: set err, go to IDLE.
  - DONE: one cycle; set done, FRAMES += 1, go to IDLE.
- Bus rules:
  - cyc/stb stay asserted and adr/dat/sel stay stable until ack or err. Classic cycles only, no bursts.
  - cyc and stb are low in IDLE and DONE.
  - A new request is never issued in the cycle that ack is sampled.
- Address rules:
  - dst address wraps modulo 2^DST_AW.
  - src address wraps modulo 2^SRC_AW.
- busy = state != IDLE.
- Abort while busy:
  - The in-flight bus cycle completes (ack or err).
  - The engine then returns to IDLE with done not set and FRAMES unchanged.
  - An abort write while in IDLE has no effect.
- Start (register or tick) while busy:
  - Ignored.
  - frame_tick while busy & auto sets overrun.
- Simultaneous start write and frame_tick in IDLE: one transfer only.
- Clearing auto mid-transfer: the current transfer finishes normally.
- Reset (asynchronous, any time): all registers 0, state IDLE, cyc/stb/we 0, irq 0, FRAMES 0. A bus cycle in flight is dropped.

Test Plan:
1. SRC=0x1000, DST=0, COUNT=4, start; src slave returns 0xAABBCCDD, ... -> four reads at 0x1000/4/8/C alternating with writes at dst adr 0..3, dat=0x00BBCCDD, sel=0x7; done=1, FRAMES=1, busy falls after DONE.
2. COUNT=0, start with ie=1 -> no src/dst cyc; done=1 and irq=1 two cycles after the start ack; W1C of STATUS bit1 drops irq.
3. auto=1, COUNT=512, frame_tick every 3000 cycles with src/dst ack latency 1 -> each tick copies 512 words; FRAMES increments per tick; overrun stays 0. Tick interval 800 -> overrun=1.
4. Abort written during WR of word 10 (dst ack delayed 5 cycles) -> that write completes, no further cycles, busy=0, done=0, FRAMES unchanged.
5. src.err on word 2 -> err=1, engine idle, only 2 dst writes issued. DST=0x1FE, COUNT=4 -> dst adr 0x1FE, 0x1FF, 0x000, 0x001.
6. rst_i asserted mid-RD with cyc high -> cyc/stb drop asynchronously, all registers read 0 after release. Writing SRC while busy -> the readback value is unchanged.
